// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave address-phase controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ACK      = 3'd2,
        SELECTED = 3'd3,
        IGNORE   = 3'd4
    } addr_state_t;

    localparam int         ADDR_BITS     = 8;
    localparam logic [6:0] GEN_CALL_ADDR = 7'h00;

    // True when the received 7-bit address selects this slave.
    function automatic logic addr_hit(
        input logic [6:0] rx_addr,
        input logic [6:0] own_addr,
        input logic       gen_call_en
    );
        addr_hit = (rx_addr == own_addr) || (gen_call_en && (rx_addr == GEN_CALL_ADDR));
    endfunction

endpackage

// File: rtl/i2c_bit_counter.sv
// Bit counter for the address byte: synchronous clear wins over enable.
module i2c_bit_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Count enabled SCL rising edges; clear on reset or START.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/i2c_slave_addr_ctrl.sv
// I2C slave address phase: START/STOP detection, address byte capture,
// address compare, ACK drive and hand-off to the data phase.
module i2c_slave_addr_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter logic       GEN_CALL_EN = 1'b0,
    parameter int         CNT_WIDTH   = 4
) (
    input  logic       FPGA_clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_drive_low,
    output logic       addr_match,
    output logic       selected,
    output logic       rw,
    output logic [7:0] addr_byte
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(ADDR_BITS);

    addr_state_t          r_state;
    addr_state_t          w_state_next;
    logic                 r_scl_q;
    logic                 r_sda_q;
    logic                 w_scl_rise;
    logic                 w_scl_fall;
    logic                 w_start;
    logic                 w_stop;
    logic [CNT_WIDTH-1:0] w_count;
    logic                 w_cnt_en;
    logic                 w_cnt_clr;
    logic                 w_cnt_full;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic                 r_sda_drive_low;
    logic                 w_sda_drive_low_next;
    logic                 r_addr_match;
    logic                 w_addr_match_next;
    logic                 r_selected;
    logic                 w_selected_next;
    logic                 r_rw;
    logic                 w_rw_next;
    logic [7:0]           r_addr_byte;
    logic [7:0]           w_addr_byte_next;

    // Bus events relative to the previous sample; SDA moving while SCL is
    // low is plain data and never qualifies as START/STOP.
    assign w_scl_rise = scl & ~r_scl_q;
    assign w_scl_fall = ~scl & r_scl_q;
    assign w_start    = scl & r_scl_q & r_sda_q & ~sda;
    assign w_stop     = scl & r_scl_q & ~r_sda_q & sda;

    assign w_cnt_clr  = rst | w_start;
    assign w_cnt_full = (w_count == CNT_FULL);

    i2c_bit_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_bit_counter (
        .clk    (FPGA_clk),
        .i_clr  (w_cnt_clr),
        .i_en   (w_cnt_en),
        .o_count(w_count)
    );

    // Previous SCL/SDA samples; idle bus level after reset.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            r_scl_q <= 1'b1;
            r_sda_q <= 1'b1;
        end else begin
            r_scl_q <= scl;
            r_sda_q <= sda;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge FPGA_clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_shift         <= 8'h00;
            r_sda_drive_low <= 1'b0;
            r_addr_match    <= 1'b0;
            r_selected      <= 1'b0;
            r_rw            <= 1'b0;
            r_addr_byte     <= 8'h00;
        end else begin
            r_state         <= w_state_next;
            r_shift         <= w_shift_next;
            r_sda_drive_low <= w_sda_drive_low_next;
            r_addr_match    <= w_addr_match_next;
            r_selected      <= w_selected_next;
            r_rw            <= w_rw_next;
            r_addr_byte     <= w_addr_byte_next;
        end
    end

    // Next state and output values; START beats STOP beats local moves.
    always_comb begin
        w_state_next         = r_state;
        w_shift_next         = r_shift;
        w_sda_drive_low_next = r_sda_drive_low;
        w_addr_match_next    = 1'b0;
        w_selected_next      = r_selected;
        w_rw_next            = r_rw;
        w_addr_byte_next     = r_addr_byte;
        w_cnt_en             = 1'b0;

        if (w_start) begin
            w_state_next         = ADDR;
            w_sda_drive_low_next = 1'b0;
            w_selected_next      = 1'b0;
        end else if (w_stop && (r_state != IDLE)) begin
            w_state_next         = IDLE;
            w_sda_drive_low_next = 1'b0;
            w_selected_next      = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_next = IDLE;
                end
                ADDR: begin
                    if (w_scl_rise && (w_count < CNT_FULL)) begin
                        w_shift_next = {r_shift[6:0], sda};
                        w_cnt_en     = 1'b1;
                    end else if (w_scl_fall && w_cnt_full) begin
                        w_addr_byte_next = r_shift;
                        if (addr_hit(r_shift[7:1], SLAVE_ADDR, GEN_CALL_EN)) begin
                            w_state_next         = ACK;
                            w_sda_drive_low_next = 1'b1;
                            w_rw_next            = r_shift[0];
                        end else begin
                            w_state_next = IGNORE;
                        end
                    end else begin
                        w_state_next = ADDR;
                    end
                end
                ACK: begin
                    // Hold SDA low through the 9th SCL high; release on its fall.
                    if (w_scl_fall) begin
                        w_state_next         = SELECTED;
                        w_sda_drive_low_next = 1'b0;
                        w_addr_match_next    = 1'b1;
                        w_selected_next      = 1'b1;
                    end else begin
                        w_state_next = ACK;
                    end
                end
                SELECTED: begin
                    w_state_next = SELECTED;
                end
                IGNORE: begin
                    w_state_next = IGNORE;
                end
                default: begin
                    w_state_next         = IDLE;
                    w_sda_drive_low_next = 1'b0;
                    w_selected_next      = 1'b0;
                end
            endcase
        end
    end

    assign sda_drive_low = r_sda_drive_low;
    assign addr_match    = r_addr_match;
    assign selected      = r_selected;
    assign rw            = r_rw;
    assign addr_byte     = r_addr_byte;

endmodule

// File: tb/tb_i2c_slave_addr_ctrl.sv
// Bench for i2c_slave_addr_ctrl: two instances (general call off / on) share
// one open-drain bus; a cycle-level reference model checks every cycle, a
// table checks whole address transactions, and hand sequences cover
// repeated START and reset during ACK.
module tb_i2c_slave_addr_ctrl;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            scl_m      = 1'b1;
    logic            sda_m      = 1'b1;
    logic            rnd_rst_en = 1'b0;
    logic            sda_bus;
    logic [1:0]      drv;
    logic [1:0]      amatch;
    logic [1:0]      sel;
    logic [1:0]      rwo;
    logic [1:0][7:0] abyte;

    logic            cap_scl;
    logic            cap_sda;
    logic            cap_rst;

    int              n_vec = 0;
    int              n_err = 0;
    int              mcnt [2];
    int              dcnt [2];

    assign sda_bus = sda_m & ~drv[0] & ~drv[1];

    always #5 clk = ~clk;

    i2c_slave_addr_ctrl #(
        .SLAVE_ADDR (7'h42),
        .GEN_CALL_EN(1'b0),
        .CNT_WIDTH  (4)
    ) u_dut0 (
        .FPGA_clk     (clk),
        .rst          (rst),
        .scl          (scl_m),
        .sda          (sda_bus),
        .sda_drive_low(drv[0]),
        .addr_match   (amatch[0]),
        .selected     (sel[0]),
        .rw           (rwo[0]),
        .addr_byte    (abyte[0])
    );

    i2c_slave_addr_ctrl #(
        .SLAVE_ADDR (7'h42),
        .GEN_CALL_EN(1'b1),
        .CNT_WIDTH  (4)
    ) u_dut1 (
        .FPGA_clk     (clk),
        .rst          (rst),
        .scl          (scl_m),
        .sda          (sda_bus),
        .sda_drive_low(drv[1]),
        .addr_match   (amatch[1]),
        .selected     (sel[1]),
        .rw           (rwo[1]),
        .addr_byte    (abyte[1])
    );

    // Capture exactly what the DUTs sample at each rising edge.
    always @(posedge clk) begin
        cap_scl <= scl_m;
        cap_sda <= sda_bus;
        cap_rst <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per slave, track whether an address is being
    // collected, its bits so far, and whether we ACK, own the bus or
    // ignore it. Expected outputs are those one clock after each sample.
    initial begin : ref_model
        logic ps, pd, s, d, st, sp, rise, fall;
        bit   collecting [2];
        bit   acking     [2];
        bit   owned      [2];
        bit   deaf       [2];
        int   nbits      [2];
        int   val        [2];
        logic e_drv [2];
        logic e_mat [2];
        logic e_sel [2];
        logic e_rw  [2];
        logic [7:0] e_ab [2];
        ps = 1'b1;
        pd = 1'b1;
        for (int k = 0; k < 2; k++) begin
            collecting[k] = 0; acking[k] = 0; owned[k] = 0; deaf[k] = 0;
            nbits[k] = 0; val[k] = 0; mcnt[k] = 0; dcnt[k] = 0;
            e_drv[k] = 1'b0; e_mat[k] = 1'b0; e_sel[k] = 1'b0; e_rw[k] = 1'b0; e_ab[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            s    = cap_scl;
            d    = cap_sda;
            st   = s && ps && pd && !d;
            sp   = s && ps && !pd && d;
            rise = s && !ps;
            fall = !s && ps;
            for (int k = 0; k < 2; k++) begin
                e_mat[k] = 1'b0;
                if (cap_rst) begin
                    collecting[k] = 0; acking[k] = 0; owned[k] = 0; deaf[k] = 0;
                    e_drv[k] = 1'b0; e_sel[k] = 1'b0; e_rw[k] = 1'b0; e_ab[k] = 8'h00;
                end else if (st) begin
                    collecting[k] = 1; acking[k] = 0; owned[k] = 0; deaf[k] = 0;
                    nbits[k] = 0; val[k] = 0;
                    e_drv[k] = 1'b0; e_sel[k] = 1'b0;
                end else if (sp && (collecting[k] || acking[k] || owned[k] || deaf[k])) begin
                    collecting[k] = 0; acking[k] = 0; owned[k] = 0; deaf[k] = 0;
                    e_drv[k] = 1'b0; e_sel[k] = 1'b0;
                end else if (collecting[k]) begin
                    if (rise && nbits[k] < 8) begin
                        val[k]   = (val[k] * 2 + int'(d)) % 256;
                        nbits[k] = nbits[k] + 1;
                    end else if (fall && nbits[k] == 8) begin
                        collecting[k] = 0;
                        e_ab[k] = val[k][7:0];
                        if ((val[k] / 2) == 'h42 || (k == 1 && (val[k] / 2) == 0)) begin
                            acking[k] = 1;
                            e_drv[k]  = 1'b1;
                            e_rw[k]   = val[k][0];
                        end else begin
                            deaf[k] = 1;
                        end
                    end
                end else if (acking[k] && fall) begin
                    acking[k] = 0;
                    owned[k]  = 1;
                    e_drv[k]  = 1'b0;
                    e_mat[k]  = 1'b1;
                    e_sel[k]  = 1'b1;
                end
                if (cap_rst) begin
                    ps = 1'b1;
                    pd = 1'b1;
                end
                check($sformatf("model_dut%0d {drv,match,sel,rw,byte}", k),
                      {20'h0, drv[k], amatch[k], sel[k], rwo[k], abyte[k]},
                      {20'h0, e_drv[k], e_mat[k], e_sel[k], e_rw[k], e_ab[k]});
                mcnt[k] += int'(amatch[k]);
                dcnt[k] += int'(drv[k]);
            end
            if (!cap_rst) begin
                ps = s;
                pd = d;
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START from idle, or repeated START from SCL low.
    task automatic bus_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; clks(5);
            scl_m = 1'b1; clks(5);
        end else begin
            sda_m = 1'b1; clks(5);
        end
        sda_m = 1'b0; clks(5);
        scl_m = 1'b0; clks(5);
    endtask

    // STOP, entered with SCL low.
    task automatic bus_stop();
        sda_m = 1'b0; clks(5);
        scl_m = 1'b1; clks(5);
        sda_m = 1'b1; clks(5);
    endtask

    // One SCL period of 20 clocks, SDA changed mid-low.
    task automatic send_bit(input logic b);
        sda_m = b; clks(5);
        scl_m = 1'b1;
        if (rnd_rst_en && $urandom_range(0, 59) == 0) begin
            clks(4); rst = 1'b1; clks(1); rst = 1'b0; clks(5);
        end else begin
            clks(10);
        end
        scl_m = 1'b0; clks(5);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic       ack0;
        logic       ack1;
    } vec_t;

    initial begin : stim
        vec_t tbl [7];
        int   m0 [2];
        int   d0 [2];
        logic [7:0] a;
        int   nb;

        tbl[0] = '{8'h84, 1'b1, 1'b1};
        tbl[1] = '{8'h85, 1'b1, 1'b1};
        tbl[2] = '{8'h90, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 1'b1};
        tbl[4] = '{8'h01, 1'b0, 1'b1};
        tbl[5] = '{8'h42, 1'b0, 1'b0};
        tbl[6] = '{8'h84, 1'b1, 1'b1};

        clks(3);
        rst = 1'b0;
        clks(2);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_dut%0d outputs", k),
                  {20'h0, drv[k], amatch[k], sel[k], rwo[k], abyte[k]}, 32'h0);
        end

        // Whole address transactions from the table.
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 2; k++) begin m0[k] = mcnt[k]; d0[k] = dcnt[k]; end
            bus_start();
            send_byte(tbl[i].addr);
            send_bit(1'b1);
            clks(6);
            for (int k = 0; k < 2; k++) begin
                logic ak;
                ak = (k == 0) ? tbl[i].ack0 : tbl[i].ack1;
                check($sformatf("tbl%0d_dut%0d match_pulses", i, k), 32'(mcnt[k] - m0[k]), ak ? 32'd1 : 32'd0);
                check($sformatf("tbl%0d_dut%0d ack_cycles", i, k), 32'(dcnt[k] - d0[k]), ak ? 32'd20 : 32'd0);
                check($sformatf("tbl%0d_dut%0d selected", i, k), 32'(sel[k]), 32'(ak));
                check($sformatf("tbl%0d_dut%0d addr_byte", i, k), 32'(abyte[k]), 32'(tbl[i].addr));
                if (ak) check($sformatf("tbl%0d_dut%0d rw", i, k), 32'(rwo[k]), 32'(tbl[i].addr[0]));
            end
            bus_stop();
            clks(3);
            for (int k = 0; k < 2; k++)
                check($sformatf("tbl%0d_dut%0d selected_after_stop", i, k), 32'(sel[k]), 32'd0);
        end

        // Repeated START after four address bits restarts the byte.
        for (int k = 0; k < 2; k++) m0[k] = mcnt[k];
        bus_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_start();
        send_byte(8'h84);
        send_bit(1'b1);
        clks(6);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rstart_dut%0d match_pulses", k), 32'(mcnt[k] - m0[k]), 32'd1);
            check($sformatf("rstart_dut%0d addr_byte", k), 32'(abyte[k]), 32'h84);
            check($sformatf("rstart_dut%0d selected", k), 32'(sel[k]), 32'd1);
        end
        bus_stop();
        clks(3);

        // Reset while driving ACK, then SCL activity without START.
        bus_start();
        send_byte(8'h84);
        sda_m = 1'b1; clks(5);
        for (int k = 0; k < 2; k++)
            check($sformatf("rst_ack_dut%0d drive_before", k), 32'(drv[k]), 32'd1);
        rst = 1'b1; clks(1); rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ack_dut%0d drive_after", k), 32'(drv[k]), 32'd0);
            check($sformatf("rst_ack_dut%0d selected_after", k), 32'(sel[k]), 32'd0);
            m0[k] = mcnt[k]; d0[k] = dcnt[k];
        end
        scl_m = 1'b1; clks(10);
        scl_m = 1'b0; clks(5);
        send_byte(8'h84);
        send_bit(1'b1);
        clks(4);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("no_start_dut%0d match_pulses", k), 32'(mcnt[k] - m0[k]), 32'd0);
            check($sformatf("no_start_dut%0d ack_cycles", k), 32'(dcnt[k] - d0[k]), 32'd0);
        end
        bus_stop();
        clks(3);

        // Randomized traffic, checked cycle by cycle by the model.
        rnd_rst_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            nb = $urandom_range(0, 99);
            if (nb < 40)      a = {7'h42, 1'($urandom_range(0, 1))};
            else if (nb < 55) a = {7'h00, 1'($urandom_range(0, 1))};
            else              a = 8'($urandom);
            bus_start();
            if ($urandom_range(0, 6) == 0) begin
                nb = $urandom_range(1, 7);
                for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
            end else begin
                send_byte(a);
                send_bit(1'b1);
                nb = $urandom_range(0, 2);
                for (int i = 0; i < nb; i++) begin
                    send_byte(8'($urandom));
                    send_bit(1'($urandom_range(0, 1)));
                end
            end
            if ($urandom_range(0, 1) == 1) bus_stop();
        end
        rnd_rst_en = 1'b0;
        if (scl_m == 1'b0) bus_stop();
        clks(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
